// File: rtl/dice_roll_accumulator_if.sv
// Result handshake between the dice accumulator (master) and its consumer (slave).
// Carries the accumulated total with a valid/ready pair.
interface dice_roll_accumulator_if #(
    parameter int SUM_W = 11
);
    logic [SUM_W-1:0] sum_out;
    logic             sum_valid;
    logic             sum_ready;

    modport master (
        output sum_out,
        output sum_valid,
        input  sum_ready
    );

    modport slave (
        input  sum_out,
        input  sum_valid,
        output sum_ready
    );
endinterface

// File: rtl/dice_roll_accumulator.sv
// Sequencer for the single-die roller: issues N roll pulses, sums the results and
// offers the NdX total on a valid/ready handshake. Optional DICE_ACC_MINMAX_EN adds min/max outputs.
module dice_roll_accumulator #(
    parameter int VAL_W    = 8,
    parameter int MAX_DICE = 8,
    parameter int CNT_W    = 4,
    parameter int SUM_W    = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_dice,
    input  logic [1:0]           die_select_in,
    output logic [1:0]           die_select,
    output logic                 roll,
    input  logic [VAL_W-1:0]     rolled_number,
    output logic                 busy,
    output logic                 error,
`ifdef DICE_ACC_MINMAX_EN
    output logic [VAL_W-1:0]     min_out,
    output logic [VAL_W-1:0]     max_out,
`endif
    dice_roll_accumulator_if.master res
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROLL,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               error_q, error_d;
    logic               num_illegal;
`ifdef DICE_ACC_MINMAX_EN
    logic [VAL_W-1:0]   min_q, min_d;
    logic [VAL_W-1:0]   max_q, max_d;
`endif

    assign num_illegal = (num_dice == '0) || (num_dice > CNT_W'(MAX_DICE));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            sum_q   <= '0;
            error_q <= 1'b0;
`ifdef DICE_ACC_MINMAX_EN
            min_q   <= '0;
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            sum_q   <= sum_d;
            error_q <= error_d;
`ifdef DICE_ACC_MINMAX_EN
            min_q   <= min_d;
            max_q   <= max_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        sum_d   = sum_q;
        error_d = 1'b0;
`ifdef DICE_ACC_MINMAX_EN
        min_d   = min_q;
        max_d   = max_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_illegal) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = S_ROLL;
                        num_d   = num_dice;
                        sel_d   = die_select_in;
                        sum_d   = '0;
                        cnt_d   = '0;
`ifdef DICE_ACC_MINMAX_EN
                        min_d   = '0;
                        max_d   = '0;
`endif
                    end
                end
            end
            S_ROLL: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                sum_d = sum_q + SUM_W'(rolled_number);
                cnt_d = cnt_q + CNT_W'(1);
`ifdef DICE_ACC_MINMAX_EN
                // The first capture seeds both extremes; later ones compare.
                if (cnt_q == '0) begin
                    min_d = rolled_number;
                    max_d = rolled_number;
                end else begin
                    if (rolled_number < min_q) min_d = rolled_number;
                    if (rolled_number > max_q) max_d = rolled_number;
                end
`endif
                state_d = (cnt_d == num_q) ? S_DONE : S_ROLL;
            end
            S_DONE: begin
                if (res.sum_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode directly from registered state so they are clean after reset.
    assign roll          = (state_q == S_ROLL);
    assign busy          = (state_q != S_IDLE);
    assign die_select    = sel_q;
    assign error         = error_q;
    assign res.sum_out   = sum_q;
    assign res.sum_valid = (state_q == S_DONE);
`ifdef DICE_ACC_MINMAX_EN
    assign min_out       = min_q;
    assign max_out       = max_q;
`endif

endmodule

// File: tb/tb_dice_roll_accumulator.sv
// Directed bench for dice_roll_accumulator with a scripted roller and a result scoreboard.
module tb_dice_roll_accumulator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  num_dice = '0;
    logic [1:0]  die_select_in = '0;
    logic [1:0]  die_select;
    logic        roll;
    logic [7:0]  rolled_number = '0;
    logic        busy;
    logic        error;
`ifdef DICE_ACC_MINMAX_EN
    logic [7:0]  min_out;
    logic [7:0]  max_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int sum;
        int mn;
        int mx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] roll_script[$];

    dice_roll_accumulator_if #(.SUM_W(11)) res_if ();

    dice_roll_accumulator #(
        .VAL_W(8), .MAX_DICE(8), .CNT_W(4), .SUM_W(11)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .num_dice      (num_dice),
        .die_select_in (die_select_in),
        .die_select    (die_select),
        .roll          (roll),
        .rolled_number (rolled_number),
        .busy          (busy),
        .error         (error),
`ifdef DICE_ACC_MINMAX_EN
        .min_out       (min_out),
        .max_out       (max_out),
`endif
        .res           (res_if.master)
    );

    always #5 clock = ~clock;

    // Roller model: answers each roll pulse with the next scripted value one cycle later.
    always @(posedge clock) begin
        if (roll === 1'b1) begin
            if (roll_script.size() > 0) rolled_number <= roll_script.pop_front();
            else                        rolled_number <= 8'd0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_op(input logic [7:0] vals[$]);
        exp_t e;
        e.sum = 0;
        e.mn  = 255;
        e.mx  = 0;
        foreach (vals[i]) begin
            roll_script.push_back(vals[i]);
            e.sum += int'(vals[i]);
            if (int'(vals[i]) < e.mn) e.mn = int'(vals[i]);
            if (int'(vals[i]) > e.mx) e.mx = int'(vals[i]);
        end
        exp_q.push_back(e);
    endtask

    task automatic start_op(input logic [3:0] n, input logic [1:0] sel);
        num_dice      = n;
        die_select_in = sel;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        num_dice      = 4'd5;
        die_select_in = ~sel;
    endtask

    task automatic wait_valid(input string tag, input int n);
        int cyc = 1;
        while (res_if.sum_valid !== 1'b1 && cyc <= 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 2 * n + 1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, res_if.sum_out, e.sum);
`ifdef DICE_ACC_MINMAX_EN
            chk({tag, "_min"}, min_out, e.mn);
            chk({tag, "_max"}, max_out, e.mx);
`endif
            $display("result %s: sum_out=%0d expected=%0d", tag, res_if.sum_out, e.sum);
        end
    endtask

    task automatic handshake(input string tag);
        res_if.sum_ready = 1'b1;
        tick();
        res_if.sum_ready = 1'b0;
        chk({tag, "_valid_drop"}, res_if.sum_valid, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_roll"}, roll, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, res_if.sum_valid, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_sum"}, res_if.sum_out, 0);
        chk({tag, "_sel"}, die_select, 0);
`ifdef DICE_ACC_MINMAX_EN
        chk({tag, "_min"}, min_out, 0);
        chk({tag, "_max"}, max_out, 0);
`endif
    endtask

    initial begin
        logic [7:0] v[$];
        res_if.sum_ready = 1'b0;

        // 1: reset with start held high
        start    = 1'b1;
        num_dice = 4'd3;
        tick();
        tick();
        check_all_zero("t1_reset");
        start = 1'b0;
        reset = 1'b0;
        tick();

        // 2: 3d(sel 01) with values 2,5,0
        v = '{8'd2, 8'd5, 8'd0};
        push_op(v);
        start_op(4'd3, 2'b01);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("t2_roll_c%0d", c), roll, ((c % 2 == 1) && (c <= 5)) ? 1 : 0);
            chk($sformatf("t2_sel_c%0d", c), die_select, 1);
            chk($sformatf("t2_valid_c%0d", c), res_if.sum_valid, (c == 7) ? 1 : 0);
            if (c < 7) tick();
        end
        check_result("t2");
        handshake("t2");

        // 3: illegal num_dice values
        for (int k = 0; k < 2; k++) begin
            num_dice = (k == 0) ? 4'd0 : 4'd9;
            start    = 1'b1;
            tick();
            start    = 1'b0;
            chk($sformatf("t3_err_pulse_%0d", k), error, 1);
            chk($sformatf("t3_busy_%0d", k), busy, 0);
            chk($sformatf("t3_roll_%0d", k), roll, 0);
            tick();
            chk($sformatf("t3_err_clear_%0d", k), error, 0);
            chk($sformatf("t3_sum_kept_%0d", k), res_if.sum_out, 7);
            $display("illegal start num_dice=%0d: error pulse checked", (k == 0) ? 0 : 9);
        end

        // 4: 2 x 255 with delayed ready, starts during DONE ignored
        v = '{8'd255, 8'd255};
        push_op(v);
        start_op(4'd2, 2'b10);
        wait_valid("t4", 2);
        check_result("t4");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_hold_valid_%0d", k), res_if.sum_valid, 1);
            chk($sformatf("t4_hold_sum_%0d", k), res_if.sum_out, 510);
            chk($sformatf("t4_hold_roll_%0d", k), roll, 0);
            if (k == 1) begin
                num_dice = 4'd1;
                start    = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        res_if.sum_ready = 1'b1;
        num_dice         = 4'd1;
        start            = 1'b1;
        tick();
        res_if.sum_ready = 1'b0;
        start            = 1'b0;
        chk("t4_valid_drop", res_if.sum_valid, 0);
        chk("t4_start_dropped", busy, 0);
        tick();
        chk("t4_still_idle", busy, 0);
        chk("t4_no_roll", roll, 0);
        chk("t4_sum_held", res_if.sum_out, 510);

        // 5: reset mid-operation, then a fresh 1d roll
        v = '{8'd1, 8'd2, 8'd3, 8'd4};
        foreach (v[i]) roll_script.push_back(v[i]);
        start_op(4'd4, 2'b11);
        repeat (4) tick();
        chk("t5_in_roll", roll, 1);
        reset = 1'b1;
        tick();
        roll_script.delete();
        check_all_zero("t5_abort");
        reset = 1'b0;
        tick();
        v = '{8'd3};
        push_op(v);
        start_op(4'd1, 2'b00);
        wait_valid("t5", 1);
        check_result("t5");
        handshake("t5");

        // 6: 4 dice with values 4,1,9,3
        v = '{8'd4, 8'd1, 8'd9, 8'd3};
        push_op(v);
        start_op(4'd4, 2'b01);
        wait_valid("t6", 4);
        check_result("t6");
        handshake("t6");

        // Largest legal count with maximum values
        v = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        push_op(v);
        start_op(4'd8, 2'b10);
        wait_valid("t7", 8);
        check_result("t7");
        handshake("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
